// File: rtl/sar_search.sv
// Successive-approximation search engine: drives MSB-first trial values into an
// external magnitude comparator and resolves the hidden k-bit operand in k decisions.
module sar_search #(
  parameter int k       = 8,
  parameter int CMP_LAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         gt,
  output logic [k-1:0] trial,
  output logic         busy,
  output logic         done,
  output logic [k-1:0] result
);

  localparam int IDX_W = (k > 2) ? $clog2(k) : 1;

  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(k - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [k-1:0]     ONE      = k'(1);
  localparam logic [k-1:0]     ZERO     = k'(0);
  localparam logic [k-1:0]     TOP_BIT  = ONE << (k - 1);
  localparam logic [3:0]       LAT_LAST = (CMP_LAT > 0) ? 4'(CMP_LAT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_TEST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_r, state_nx_s;
  logic [IDX_W-1:0] idx_r, idx_nx_s, idx_dec_s;
  logic [3:0]       cnt_r, cnt_nx_s;
  logic [k-1:0]     trial_nx_s, result_nx_s, decided_s;
  logic             busy_nx_s, done_nx_s;

  // Keep the trial bit under test only when the comparator says it does not overshoot.
  always_comb begin
    idx_dec_s = idx_r - IDX_ONE;
    if (gt) begin
      decided_s = trial & ~(ONE << idx_r);
    end else begin
      decided_s = trial;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx_s  = state_r;
    idx_nx_s    = idx_r;
    cnt_nx_s    = cnt_r;
    trial_nx_s  = trial;
    result_nx_s = result;
    busy_nx_s   = busy;
    done_nx_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          result_nx_s = ZERO;
          trial_nx_s  = TOP_BIT;
          idx_nx_s    = IDX_TOP;
          cnt_nx_s    = 4'd0;
          busy_nx_s   = 1'b1;
          state_nx_s  = (CMP_LAT > 0) ? S_WAIT : S_TEST;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == LAT_LAST) begin
          state_nx_s = S_TEST;
        end else begin
          cnt_nx_s = cnt_r + 4'd1;
        end
      end
      S_TEST: begin
        result_nx_s = decided_s;
        if (idx_r != IDX_ZERO) begin
          trial_nx_s = decided_s | (ONE << idx_dec_s);
          idx_nx_s   = idx_dec_s;
          cnt_nx_s   = 4'd0;
          state_nx_s = (CMP_LAT > 0) ? S_WAIT : S_TEST;
        end else begin
          // Park the trial on the answer so it matches result once done.
          trial_nx_s = decided_s;
          busy_nx_s  = 1'b0;
          done_nx_s  = 1'b1;
          state_nx_s = S_DONE;
        end
      end
      S_DONE: begin
        state_nx_s = S_IDLE;
      end
      default: begin
        state_nx_s = S_IDLE;
        busy_nx_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      idx_r   <= IDX_TOP;
      cnt_r   <= 4'd0;
      trial   <= ZERO;
      result  <= ZERO;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
      cnt_r   <= cnt_nx_s;
      trial   <= trial_nx_s;
      result  <= result_nx_s;
      busy    <= busy_nx_s;
      done    <= done_nx_s;
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: three instances (comparator latency 0, 1, 2)
// checked against a binary-search reference model with exact cycle timing.
module tb_sar_search;

  logic       clk;
  logic       rst_n;
  logic [2:0] start;
  logic [7:0] target;

  logic       gt0, gt1, gt2;
  logic       gt1_q, gt2_a, gt2_b;
  logic [7:0] trial0, trial1, trial2;
  logic [7:0] result0, result1, result2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  int vectors;
  int miscompares;

  sar_search #(.k(8), .CMP_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .gt(gt0),
    .trial(trial0), .busy(busy0), .done(done0), .result(result0)
  );
  sar_search #(.k(8), .CMP_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .gt(gt1),
    .trial(trial1), .busy(busy1), .done(done1), .result(result1)
  );
  sar_search #(.k(8), .CMP_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .gt(gt2),
    .trial(trial2), .busy(busy2), .done(done2), .result(result2)
  );

  // Behavioural comparators: combinational, one register, two registers.
  assign gt0 = (trial0 > target);
  always_ff @(posedge clk) begin
    gt1_q <= (trial1 > target);
    gt2_a <= (trial2 > target);
    gt2_b <= gt2_a;
  end
  assign gt1 = gt1_q;
  assign gt2 = gt2_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int u, output logic [7:0] tr, output logic bz,
                        output logic dn, output logic [7:0] rs);
    case (u)
      0:       begin tr = trial0; bz = busy0; dn = done0; rs = result0; end
      1:       begin tr = trial1; bz = busy1; dn = done1; rs = result1; end
      default: begin tr = trial2; bz = busy2; dn = done2; rs = result2; end
    endcase
  endtask

  // One full search on instance u; optionally re-pulse start mid-search.
  task automatic run_search(input int u, input logic [7:0] tgt, input int lat, input bit repulse);
    logic [7:0] exp_tr [8];
    logic [7:0] acc;
    logic [7:0] cand;
    logic [7:0] tr, rs;
    logic       bz, dn;
    int         n_done;
    acc = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      cand = acc | (8'd1 << i);
      exp_tr[7 - i] = cand;
      if (cand <= tgt) acc = cand;
    end
    n_done = 8 * (1 + lat);
    target = tgt;
    @(negedge clk);
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
    for (int n = 0; n <= n_done + 1; n++) begin
      sample(u, tr, bz, dn, rs);
      if (n < n_done) begin
        check("trial", {24'd0, tr}, {24'd0, exp_tr[n / (1 + lat)]});
        check("busy", {31'd0, bz}, 32'd1);
        check("done_early", {31'd0, dn}, 32'd0);
      end else if (n == n_done) begin
        check("done", {31'd0, dn}, 32'd1);
        check("busy_in_done", {31'd0, bz}, 32'd0);
        check("result", {24'd0, rs}, {24'd0, tgt});
        check("trial_final", {24'd0, tr}, {24'd0, acc});
      end else begin
        check("done_pulse", {31'd0, dn}, 32'd0);
        check("result_hold", {24'd0, rs}, {24'd0, tgt});
      end
      start[u] = repulse && (n == 2 || n == 6);
      @(negedge clk);
    end
    start[u] = 1'b0;
  endtask

  initial begin
    logic [7:0] tr, rs;
    logic       bz, dn;
    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    start  = 3'b000;
    target = 8'h00;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      sample(u, tr, bz, dn, rs);
      check("rst_trial", {24'd0, tr}, 32'd0);
      check("rst_result", {24'd0, rs}, 32'd0);
      check("rst_busy", {31'd0, bz}, 32'd0);
      check("rst_done", {31'd0, dn}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_search(0, 8'hA5, 0, 1'b0);
    run_search(0, 8'h00, 0, 1'b0);
    run_search(0, 8'hFF, 0, 1'b0);
    run_search(2, 8'h3C, 2, 1'b0);
    run_search(0, 8'h5A, 0, 1'b1);
    run_search(0, 8'h33, 0, 1'b0);
    run_search(2, 8'h5A, 2, 1'b1);

    // Reset in the middle of a search aborts it without a done pulse.
    target = 8'h42;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sample(0, tr, bz, dn, rs);
    check("abort_trial", {24'd0, tr}, 32'd0);
    check("abort_result", {24'd0, rs}, 32'd0);
    check("abort_busy", {31'd0, bz}, 32'd0);
    check("abort_done", {31'd0, dn}, 32'd0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      sample(0, tr, bz, dn, rs);
      check("abort_no_done", {31'd0, dn}, 32'd0);
      check("abort_idle", {31'd0, bz}, 32'd0);
    end
    run_search(0, 8'h81, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_search(2, 8'($urandom_range(0, 255)), 2, 1'b0);
    end
    for (int t = 0; t < 256; t++) begin
      run_search(0, 8'(t), 0, 1'b0);
    end
    for (int t = 0; t < 256; t++) begin
      run_search(1, 8'(t), 1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search engine: the initiator side of the magnitude-compare interface. On `start` it drives k trial values MSB-first into an external comparator and reads back one greater-than bit per trial. It resolves the hidden k-bit operand on the comparator's other input exactly, in k decisions. It sits beside a `MagComp`-style comparator (a = `trial`, b = target) and is used wherever a value is only observable through comparisons.

## Interface
- `k`, 8: operand width in bits, ≥ 2.
- `CMP_LAT`, 0: extra wait cycles per trial for a registered or pipelined comparator, 0..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  request a search; honoured only in IDLE.
- `gt`  in  1  comparator result, 1 when `trial` > target.
- `trial`  out  k  registered trial value presented to the comparator.
- `busy`  out  1  high in TEST and WAIT.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  k  resolved target; holds until the next accepted `start`.

## Operation
- All outputs are registered. Reset values: `trial`=0, `result`=0, `busy`=0, `done`=0, state IDLE, bit index = k-1, wait counter = 0.
- **IDLE**:
  - `start`=1 → `result`<=0, `trial`<=1<<(k-1), index<=k-1, wait counter<=0, go to TEST (or WAIT if CMP_LAT>0).
  - `start`=0 → stay; `trial` holds.
- **WAIT** (only when CMP_LAT>0):
  - Counts CMP_LAT cycles with `trial` stable.
  - When the count reaches CMP_LAT-1, go to TEST.
- **TEST** (decision edge, `gt` sampled):
  - Decided value d = `trial` if `gt`=0, else `trial` with bit[index] cleared.
  - `result`<=d.
  - If index>0: `trial`<=d | 1<<(index-1), index<=index-1, counter<=0, go to WAIT/TEST.
  - If index=0: go to DONE.
- **DONE**: `done`=1 and `busy`=0 for exactly one cycle, then IDLE. `result` = target. `trial` holds its final value, which equals `result`.
- `start` is ignored in TEST, WAIT and DONE. It is not queued.
- A target of 0 or 2^k−1 needs no special handling. All arithmetic is unsigned, k bits, with no carry.
- `gt` is sampled only at the TEST decision edge. Its value in all other cycles is don't-care.
- The target must be stable from `start` acceptance to `done`. If it changes mid-search, `result` is undefined but the FSM still terminates in exactly k decisions.
- Reset mid-search: at the next edge with `rst_n`=0, all state returns to reset values. No `done` is produced for the aborted search.

## Timing
- Edge E0 samples `start` in IDLE. The first trial is visible in the cycle after E0.
- Decision for bit i occurs at edge E0 + (k−i)(1+CMP_LAT).
- The last decision is at E0 + k(1+CMP_LAT). `done` is high during the following cycle.
- `busy` rises the cycle after E0 and falls in the DONE cycle.
- Latency from the start edge to the `done` cycle: k(1+CMP_LAT) cycles. Examples: k=8, CMP_LAT=0 → 8; CMP_LAT=2 → 24.
- Back-to-back searches: earliest next acceptance is the IDLE cycle after DONE, so throughput is one search per k(1+CMP_LAT)+2 cycles.
- With CMP_LAT=0, `gt` must settle combinationally from `trial` within one cycle.

## Test plan
- k=8, CMP_LAT=0, target 0xA5, behavioural comparator → `trial` sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; `result`=0xA5 with `done` 8 cycles after the start edge.
- Target 0x00 → trials 0x80,0x40,...,0x01, all with `gt`=1; `result`=0x00. Target 0xFF → trials 0x80,0xC0,...,0xFF, all with `gt`=0; `result`=0xFF.
- CMP_LAT=2, comparator output delayed 2 registers, target 0x3C → `trial` stable 3 cycles per bit; `done` at cycle 24; `result`=0x3C.
- Pulse `start` again at cycles 3 and 7 of a search for target 0x5A → ignored; single `done`; `result`=0x5A; the next `start` after DONE runs a fresh search.
- Drop `rst_n` low for one cycle at cycle 4 → all outputs 0 and state IDLE the following cycle, no `done`; a new `start` then resolves 0x81 correctly.
- Exhaustive sweep of all 256 targets for k=8 with CMP_LAT 0 and 1 → `result`==target every time, with the `done` latency exact.
